// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing constants and helpers for sync_fifo.
package fifo_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;
    localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

    function automatic int depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: put/get strobes, data and status of sync_fifo.
// overflow/underflow exist only when SYNC_FIFO_ERR_EN is defined.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                en_put;
    logic [DATA_W-1:0]   data_in;
    logic                en_get;
    logic [DATA_W-1:0]   data_out;
    logic                full;
    logic                empty;
    logic [ADDR_W:0]     count;
`ifdef SYNC_FIFO_ERR_EN
    logic                overflow;
    logic                underflow;
`endif

    modport master (
        output en_put, data_in, en_get,
`ifdef SYNC_FIFO_ERR_EN
        input  overflow, underflow,
`endif
        input  data_out, full, empty, count
    );

    modport slave (
        input  en_put, data_in, en_get,
`ifdef SYNC_FIFO_ERR_EN
        output overflow, underflow,
`endif
        output data_out, full, empty, count
    );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, one write port, one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int DEPTH = depth(ADDR_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    always_ff @(posedge clk)
        if (reset) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, flags and occupancy.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic clk,
    input logic reset,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = depth(ADDR_W);
    localparam int CNT_W = cnt_w(ADDR_W);

    logic [CNT_W-1:0]  r_wr_ptr, r_rd_ptr, r_count;
    logic              r_full, r_empty;
    logic              w_put_ok, w_get_ok;
    logic [CNT_W-1:0]  w_next_count;
    logic [DATA_W-1:0] w_rdata;

    assign w_put_ok     = bus.en_put & ~r_full;
    assign w_get_ok     = bus.en_get & ~r_empty;
    assign w_next_count = r_count + CNT_W'(w_put_ok) - CNT_W'(w_get_ok);

    // Flags come from next_count so they line up with the registered count.
    always_ff @(posedge clk)
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + CNT_W'(w_put_ok);
            r_rd_ptr <= r_rd_ptr + CNT_W'(w_get_ok);
            r_count  <= w_next_count;
            r_full   <= w_next_count == CNT_W'(DEPTH);
            r_empty  <= w_next_count == '0;
        end

    fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_put_ok),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (bus.data_in),
        .i_re    (w_get_ok),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic r_overflow, r_underflow;

    always_ff @(posedge clk)
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow | (bus.en_put & r_full & ~bus.en_get);
            r_underflow <= r_underflow | (bus.en_get & r_empty);
        end

    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
`endif

    assign bus.data_out = w_rdata;
    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.count    = r_count;
endmodule
